// File: rtl/guess_round_ctrl.sv
// Bulls-and-Cows round sequencer: digit entry, check hand-off, attempt count, win/lose.
// Optional DUP_REJECT_EN: reject a digit already present in the partial guess.
module guess_round_ctrl #(
    parameter int MAX_TRIES = 10,
    parameter int CHECK_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        clear,
    input  logic        new_game,
    input  logic [3:0]  strike,
    input  logic [3:0]  ball,
    output logic [15:0] guess,
    output logic [2:0]  entry_cnt,
    output logic        check_en,
    output logic [3:0]  last_strike,
    output logic [3:0]  last_ball,
    output logic [3:0]  attempts,
    output logic        correct,
    output logic        lose,
    output logic        dup_err
);

    typedef enum logic [2:0] {
        ENTRY = 3'd0,
        CHECK = 3'd1,
        JUDGE = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [2:0]  lat_cnt, lat_cnt_n;
    logic [15:0] guess_n;
    logic [2:0]  entry_cnt_n;
    logic [3:0]  last_strike_n, last_ball_n, attempts_n;
    logic        dup_err_n;
    logic        dig_ok, dup_hit;

    assign dig_ok = digit_valid && (digit <= 4'd9);

`ifdef DUP_REJECT_EN
    // Unentered nibbles hold 4'hF, which never matches a legal digit.
    assign dup_hit = (digit == guess[15:12]) || (digit == guess[11:8]) ||
                     (digit == guess[7:4])   || (digit == guess[3:0]);
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        state_n       = state;
        lat_cnt_n     = lat_cnt;
        guess_n       = guess;
        entry_cnt_n   = entry_cnt;
        last_strike_n = last_strike;
        last_ball_n   = last_ball;
        attempts_n    = attempts;
        dup_err_n     = 1'b0;

        if (new_game) begin
            state_n     = ENTRY;
            lat_cnt_n   = 3'd0;
            guess_n     = 16'hFFFF;
            entry_cnt_n = 3'd0;
            attempts_n  = 4'd0;
        end else begin
            case (state)
                ENTRY: begin
                    if (clear) begin
                        guess_n     = 16'hFFFF;
                        entry_cnt_n = 3'd0;
                    end else if (dig_ok) begin
                        if (dup_hit) begin
                            dup_err_n = 1'b1;
                        end else begin
                            case (entry_cnt)
                                3'd0:    guess_n[15:12] = digit;
                                3'd1:    guess_n[11:8]  = digit;
                                3'd2:    guess_n[7:4]   = digit;
                                default: guess_n[3:0]   = digit;
                            endcase
                            entry_cnt_n = entry_cnt + 3'd1;
                            if (entry_cnt == 3'd3) begin
                                state_n   = CHECK;
                                lat_cnt_n = 3'd0;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (lat_cnt == 3'(CHECK_LAT - 1)) begin
                        last_strike_n = strike;
                        last_ball_n   = ball;
                        state_n       = JUDGE;
                    end else begin
                        lat_cnt_n = lat_cnt + 3'd1;
                    end
                end
                JUDGE: begin
                    attempts_n = (attempts == 4'd15) ? 4'd15 : attempts + 4'd1;
                    if (last_strike == 4'd4) begin
                        state_n = WIN;
                    end else if (({1'b0, attempts} + 5'd1) == 5'(MAX_TRIES)) begin
                        state_n = LOSE;
                    end else begin
                        state_n     = ENTRY;
                        guess_n     = 16'hFFFF;
                        entry_cnt_n = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ENTRY;
            lat_cnt     <= 3'd0;
            guess       <= 16'hFFFF;
            entry_cnt   <= 3'd0;
            last_strike <= 4'd0;
            last_ball   <= 4'd0;
            attempts    <= 4'd0;
            check_en    <= 1'b0;
            correct     <= 1'b0;
            lose        <= 1'b0;
            dup_err     <= 1'b0;
        end else begin
            state       <= state_n;
            lat_cnt     <= lat_cnt_n;
            guess       <= guess_n;
            entry_cnt   <= entry_cnt_n;
            last_strike <= last_strike_n;
            last_ball   <= last_ball_n;
            attempts    <= attempts_n;
            check_en    <= (state_n == CHECK);
            correct     <= (state_n == WIN);
            lose        <= (state_n == LOSE);
            dup_err     <= dup_err_n;
        end
    end

endmodule
